// File: rtl/reaction_session_ctrl_pkg.sv
// Shared types and constants for the reaction-time session controller.
// Includes the state and display-select enums, the LED colours and a saturating count helper.
package reaction_session_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE, ARM, WAIT, GO, RECORD, EARLY, LATE, GAP, SUMMARY
  } state_e;

  typedef enum logic [1:0] {
    DISP_BLANK = 2'd0,
    DISP_TIME  = 2'd1,
    DISP_BEST  = 2'd2,
    DISP_WORST = 2'd3
  } disp_sel_e;

  // LED colours, packed as {r,g,b}
  localparam logic [2:0] LED_OFF    = 3'b000;
  localparam logic [2:0] LED_RED    = 3'b100;
  localparam logic [2:0] LED_GREEN  = 3'b010;
  localparam logic [2:0] LED_BLUE   = 3'b001;
  localparam logic [2:0] LED_YELLOW = 3'b110;
  localparam logic [2:0] LED_WHITE  = 3'b111;

  localparam logic [15:0] BCD_MAX = 16'h9999;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/reaction_session_ctrl_if.sv
// Bundles the signals between the controller and the button/counter/display datapath.
interface reaction_session_ctrl_if;
  logic        start_pulse;
  logic        enter_pulse;
  logic [2:0]  rand_val;
  logic [15:0] time_bcd;
  logic        time_carry;
  logic        cnt_clr;
  logic        cnt_run;
  logic [2:0]  led_rgb;
  logic [1:0]  disp_sel;
  logic [15:0] disp_bcd;
  logic [3:0]  trial_idx;
  logic [3:0]  early_cnt;
  logic [3:0]  late_cnt;
  logic        done;

  modport master (
    output start_pulse, enter_pulse, rand_val, time_bcd, time_carry,
    input  cnt_clr, cnt_run, led_rgb, disp_sel, disp_bcd, trial_idx, early_cnt, late_cnt, done
  );

  modport slave (
    input  start_pulse, enter_pulse, rand_val, time_bcd, time_carry,
    output cnt_clr, cnt_run, led_rgb, disp_sel, disp_bcd, trial_idx, early_cnt, late_cnt, done
  );
endinterface

// File: rtl/reaction_session_ctrl_score_keeper.sv
// Holds the last, best and worst valid reaction times for a session.
// BCD-packed values order correctly when they are compared as plain unsigned numbers.
module reaction_session_ctrl_score_keeper
  import reaction_session_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        upd_i,
  input  logic [15:0] time_i,
  output logic [15:0] last_o,
  output logic [15:0] best_o,
  output logic [15:0] worst_o
);

  logic [15:0] last_q, last_d;
  logic [15:0] best_q, best_d;
  logic [15:0] worst_q, worst_d;

  always_comb begin
    last_d  = last_q;
    best_d  = best_q;
    worst_d = worst_q;
    if (clr_i) begin
      last_d  = '0;
      best_d  = BCD_MAX;
      worst_d = '0;
    end else if (upd_i) begin
      last_d = time_i;
      if (time_i < best_q)  best_d  = time_i;
      if (time_i > worst_q) worst_d = time_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q  <= '0;
      best_q  <= BCD_MAX;
      worst_q <= '0;
    end else begin
      last_q  <= last_d;
      best_q  <= best_d;
      worst_q <= worst_d;
    end
  end

  assign last_o  = last_q;
  assign best_o  = best_q;
  assign worst_o = worst_q;

endmodule

// File: rtl/reaction_session_ctrl.sv
// Runs a multi-trial reaction-time session on the external BCD millisecond counter.
// Each trial goes through a random wait, the GO light, then either press capture or an early/late penalty.
module reaction_session_ctrl
  import reaction_session_ctrl_pkg::*;
#(
  parameter int NUM_TRIALS = 5,
  parameter int PENALTY_S  = 5,
  parameter int MIN_WAIT_S = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  reaction_session_ctrl_if.slave io
);

  localparam logic [3:0] TRIALS  = 4'(NUM_TRIALS);
  localparam logic [3:0] PEN_LIM = 4'(PENALTY_S);

  state_e      state_q, state_d;
  disp_sel_e   sum_sel_q, sum_sel_d;
  logic [2:0]  wait_s_q, wait_s_d;
  logic [3:0]  trial_q, trial_d;
  logic [3:0]  early_q, early_d;
  logic [3:0]  late_q, late_d;
  logic        clr_evt, sk_clr, sk_upd;
  logic [15:0] last_t, best_t, worst_t;
  logic [3:0]  d3, wait_lim;
  logic        wait_done, pen_done;

  assign d3        = io.time_bcd[15:12];
  assign wait_lim  = {1'b0, wait_s_q} + 4'(MIN_WAIT_S);
  assign wait_done = (d3 >= wait_lim);
  assign pen_done  = (d3 >= PEN_LIM);

  // The press time is captured on the press cycle itself, so it is visible in RECORD.
  reaction_session_ctrl_score_keeper u_score (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (sk_clr),
    .upd_i   (sk_upd),
    .time_i  (io.time_bcd),
    .last_o  (last_t),
    .best_o  (best_t),
    .worst_o (worst_t)
  );

  always_comb begin
    state_d   = state_q;
    sum_sel_d = sum_sel_q;
    wait_s_d  = wait_s_q;
    trial_d   = trial_q;
    early_d   = early_q;
    late_d    = late_q;
    clr_evt   = 1'b0;
    sk_clr    = 1'b0;
    sk_upd    = 1'b0;
    case (state_q)
      IDLE: if (io.start_pulse) begin
        state_d = ARM;
        trial_d = 4'd1;
        early_d = '0;
        late_d  = '0;
        sk_clr  = 1'b1;
      end
      ARM: begin
        wait_s_d = io.rand_val;
        state_d  = WAIT;
      end
      WAIT: if (wait_done) begin
        state_d = GO;
        clr_evt = 1'b1;
      end else if (io.enter_pulse) begin
        state_d = EARLY;
        clr_evt = 1'b1;
        early_d = sat_inc(early_q);
      end
      GO: if (io.enter_pulse) begin
        state_d = RECORD;
        sk_upd  = 1'b1;
      end else if (io.time_carry) begin
        state_d = LATE;
        clr_evt = 1'b1;
        late_d  = sat_inc(late_q);
      end
      RECORD: state_d = GAP;
      EARLY, LATE, GAP: if (pen_done) begin
        if (trial_q == TRIALS) begin
          state_d   = SUMMARY;
          sum_sel_d = DISP_TIME;
        end else begin
          state_d = ARM;
          trial_d = trial_q + 4'd1;
        end
      end
      SUMMARY: if (io.start_pulse) begin
        state_d = IDLE;
        trial_d = '0;
      end else if (io.enter_pulse) begin
        case (sum_sel_q)
          DISP_TIME: sum_sel_d = DISP_BEST;
          DISP_BEST: sum_sel_d = DISP_WORST;
          default:   sum_sel_d = DISP_TIME;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sum_sel_q <= DISP_BLANK;
      wait_s_q  <= '0;
      trial_q   <= '0;
      early_q   <= '0;
      late_q    <= '0;
    end else begin
      state_q   <= state_d;
      sum_sel_q <= sum_sel_d;
      wait_s_q  <= wait_s_d;
      trial_q   <= trial_d;
      early_q   <= early_d;
      late_q    <= late_d;
    end
  end

  // Clear is also raised on the transition cycle so the next state starts from 0000.
  always_comb begin
    io.cnt_clr  = clr_evt;
    io.cnt_run  = 1'b0;
    io.led_rgb  = LED_OFF;
    io.disp_sel = DISP_BLANK;
    io.disp_bcd = '0;
    io.done     = 1'b0;
    case (state_q)
      IDLE: begin
        io.cnt_clr = 1'b1;
        io.led_rgb = LED_GREEN;
      end
      ARM:  io.cnt_clr = 1'b1;
      WAIT: io.cnt_run = 1'b1;
      GO: begin
        io.cnt_run  = 1'b1;
        io.led_rgb  = LED_WHITE;
        io.disp_sel = DISP_TIME;
        io.disp_bcd = io.time_bcd;
      end
      RECORD: begin
        io.cnt_clr  = 1'b1;
        io.disp_sel = DISP_TIME;
        io.disp_bcd = last_t;
      end
      EARLY: begin
        io.cnt_run = 1'b1;
        io.led_rgb = LED_RED;
      end
      LATE: begin
        io.cnt_run = 1'b1;
        io.led_rgb = LED_YELLOW;
      end
      GAP: begin
        io.cnt_run  = 1'b1;
        io.disp_sel = DISP_TIME;
        io.disp_bcd = last_t;
      end
      SUMMARY: begin
        io.cnt_clr  = 1'b1;
        io.led_rgb  = LED_BLUE;
        io.done     = 1'b1;
        io.disp_sel = sum_sel_q;
        case (sum_sel_q)
          DISP_TIME:  io.disp_bcd = last_t;
          DISP_BEST:  io.disp_bcd = best_t;
          DISP_WORST: io.disp_bcd = worst_t;
          default:    io.disp_bcd = '0;
        endcase
      end
      default: io.cnt_clr = 1'b1;
    endcase
  end

  assign io.trial_idx = trial_q;
  assign io.early_cnt = early_q;
  assign io.late_cnt  = late_q;

endmodule
